// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates instruction fetch and data requests onto one RAM port,
// data first, with a starvation counter that forces an instruction grant.
module memory_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int WORD_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  localparam logic [1:0] ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  state_t          state;
  logic [CW-1:0]   starve_cnt;
  logic            dreq, i_act, d_act, i_done, d_done;

  assign dreq   = dREN | dWEN;
  // a granted requester that drops its request aborts; enables fall in the same cycle
  assign i_act  = state == IGRANT && iREN;
  assign d_act  = state == DGRANT && dreq;
  assign i_done = i_act && ramstate == ACCESS;
  assign d_done = d_act && ramstate == ACCESS;

  assign ramREN   = i_act | (d_act & ~dWEN);
  assign ramWEN   = d_act & dWEN;
  assign ramaddr  = state == IGRANT ? iaddr : state == DGRANT ? daddr : '0;
  assign ramstore = state == DGRANT ? dstore : '0;
  assign iwait    = ~i_done;
  assign dwait    = ~d_done;
  assign iload    = ramload;
  assign dload    = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      if (state == IDLE)
        state <= (dreq && !(iREN && starve_cnt == SMAX)) ? DGRANT : iREN ? IGRANT : IDLE;
      else if (!(i_act || d_act) || i_done || d_done)
        state <= IDLE;
      if (i_done || (d_done && !iREN))
        starve_cnt <= '0;
      else if (d_done && starve_cnt != SMAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: per-cycle vector table through a scoreboard queue, plus a
// hand-written asynchronous reset sequence.
module tb_memory_arbiter;
  localparam logic [31:0] IA = 32'h40, DA = 32'h100, DS = 32'hDEADBEEF, LD = 32'h8C220004;
  localparam logic [1:0] FR = 2'd0, BZ = 2'd1, AC = 2'd2, ER = 2'd3;

  logic        CLK = 0, nRST = 0, iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = IA, daddr = DA, dstore = DS, ramload = LD;
  logic [1:0]  ramstate = FR;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN;

  memory_arbiter #(.STARVE_MAX(4), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic i, d, w;
    logic [1:0] rs;
    logic ren, wen;
    logic [31:0] addr, store;
    logic iw, dw;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int n_chk = 0, n_fail = 0;

  function automatic vec_t v(logic i, d, w, logic [1:0] rs, logic ren, wen,
                             logic [31:0] addr, store, logic iw, dw);
    vec_t r;
    r.i = i; r.d = d; r.w = w; r.rs = rs; r.ren = ren; r.wen = wen;
    r.addr = addr; r.store = store; r.iw = iw; r.dw = dw;
    return r;
  endfunction

  function automatic vec_t idle(logic i, d, w);
    return v(i, d, w, FR, 0, 0, 0, 0, 1, 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // single fetch: BUSY twice, then ACCESS
    tbl.push_back(idle(1, 0, 0));
    tbl.push_back(v(1, 0, 0, BZ, 1, 0, IA, 0, 1, 1));
    tbl.push_back(v(1, 0, 0, BZ, 1, 0, IA, 0, 1, 1));
    tbl.push_back(v(1, 0, 0, AC, 1, 0, IA, 0, 0, 1));
    tbl.push_back(idle(0, 0, 0));
    // contention: data first, IDLE between grants
    tbl.push_back(idle(1, 1, 0));
    tbl.push_back(v(1, 1, 0, AC, 1, 0, DA, DS, 1, 0));
    tbl.push_back(idle(1, 0, 0));
    tbl.push_back(v(1, 0, 0, AC, 1, 0, IA, 0, 0, 1));
    tbl.push_back(idle(0, 0, 0));
    // starvation: four data grants, then the fetch, then data again
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(idle(1, 1, 0));
      tbl.push_back(v(1, 1, 0, AC, 1, 0, DA, DS, 1, 0));
    end
    tbl.push_back(idle(1, 1, 0));
    tbl.push_back(v(1, 1, 0, AC, 1, 0, IA, 0, 0, 1));
    tbl.push_back(idle(1, 1, 0));
    tbl.push_back(v(1, 1, 0, AC, 1, 0, DA, DS, 1, 0));
    tbl.push_back(idle(0, 0, 0));
    // write priority then abort while BUSY
    tbl.push_back(idle(0, 1, 1));
    tbl.push_back(v(0, 1, 1, BZ, 0, 1, DA, DS, 1, 1));
    tbl.push_back(v(0, 0, 0, BZ, 0, 0, DA, DS, 1, 1));
    tbl.push_back(idle(0, 0, 0));
    // error retry on a fetch
    tbl.push_back(idle(1, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(1, 0, 0, ER, 1, 0, IA, 0, 1, 1));
    tbl.push_back(v(1, 0, 0, AC, 1, 0, IA, 0, 0, 1));
    tbl.push_back(idle(0, 0, 0));

    repeat (2) @(negedge CLK);
    nRST = 1;
    for (int n = 0; n < tbl.size(); n++) begin
      vec_t e;
      @(negedge CLK);
      iREN = tbl[n].i; dREN = tbl[n].d; dWEN = tbl[n].w; ramstate = tbl[n].rs;
      sb.push_back(tbl[n]);
      #1;
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL row%0d: scoreboard empty", n);
        continue;
      end
      e = sb.pop_front();
      chk($sformatf("row%0d ramREN", n), 32'(ramREN), 32'(e.ren));
      chk($sformatf("row%0d ramWEN", n), 32'(ramWEN), 32'(e.wen));
      chk($sformatf("row%0d ramaddr", n), ramaddr, e.addr);
      chk($sformatf("row%0d ramstore", n), ramstore, e.store);
      chk($sformatf("row%0d iwait", n), 32'(iwait), 32'(e.iw));
      chk($sformatf("row%0d dwait", n), 32'(dwait), 32'(e.dw));
      if (!e.iw) chk($sformatf("row%0d iload", n), iload, LD);
      if (!e.dw) chk($sformatf("row%0d dload", n), dload, LD);
    end

    // asynchronous reset in the middle of a write grant
    @(negedge CLK);
    dWEN = 1; ramstate = BZ;
    #1 chk("rst pre idle ramWEN", 32'(ramWEN), 0);
    @(negedge CLK);
    #1 chk("rst granted ramWEN", 32'(ramWEN), 1);
    #2 nRST = 0;
    #1;
    chk("rst ramWEN", 32'(ramWEN), 0);
    chk("rst ramREN", 32'(ramREN), 0);
    chk("rst dwait", 32'(dwait), 1);
    chk("rst iwait", 32'(iwait), 1);
    chk("rst ramaddr", ramaddr, 0);
    chk("rst ramstore", ramstore, 0);
    dWEN = 0;
    @(negedge CLK);
    nRST = 1; dREN = 1; ramstate = AC;
    #1;
    chk("post rst idle ramREN", 32'(ramREN), 0);
    chk("post rst idle dwait", 32'(dwait), 1);
    @(negedge CLK);
    #1;
    chk("post rst grant ramREN", 32'(ramREN), 1);
    chk("post rst grant ramaddr", ramaddr, DA);
    chk("post rst grant dwait", 32'(dwait), 0);
    dREN = 0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
